// File: rtl/tblink_rpc_pktbuf_if.sv
// 8-bit ready/valid byte stream used on both sides of the packet buffer.
// master drives dat/valid, slave drives ready.
interface tblink_rpc_pktbuf_if;
  logic [7:0] dat;
  logic       valid;
  logic       ready;

  modport master (output dat, output valid, input ready);
  modport slave  (input dat, input valid, output ready);
endinterface

// File: rtl/tblink_rpc_pktbuf.sv
// Store-and-forward packet buffer for the host byte stream.
// Packets are [addr][len L][L payload bytes]. Bytes are written at a
// speculative pointer and only become visible to the read side once the
// whole packet has arrived; oversized packets are swallowed.
// Optional statistics counters: define TBLINK_RPC_PKTBUF_STATS_EN.
//
// state   | meaning
// --------+---------------------------------------------------------
// WR_HDR  | waiting for the address byte of a new packet
// WR_LEN  | waiting for the length byte; decides store or drop
// WR_BODY | storing payload bytes, commit on the last one
// WR_DROP | swallowing payload of an oversized packet
// RD_HDR  | next output byte is an address byte
// RD_LEN  | next output byte is a length byte
// RD_BODY | emitting payload, packet completes on the last byte
module tblink_rpc_pktbuf #(
  parameter int DEPTH   = 64,
  parameter int DEPTH_W = $clog2(DEPTH)
) (
  input  logic                uclock,
  input  logic                reset,
  tblink_rpc_pktbuf_if.slave  i,
  tblink_rpc_pktbuf_if.master o,
  output logic [DEPTH_W:0]    pkt_avail,
  output logic                drop_pulse,
  output logic [15:0]         stat_pkts,
  output logic [15:0]         stat_drops
);
  typedef logic [DEPTH_W:0] ptr_t;
  typedef enum logic [1:0] {WR_HDR, WR_LEN, WR_BODY, WR_DROP} wr_state_t;
  typedef enum logic [1:0] {RD_HDR, RD_LEN, RD_BODY} rd_state_t;

  logic [7:0] mem [DEPTH];
  ptr_t       wr_spec, wr_cmt, rd;
  wr_state_t  wr_state, wr_state_nxt;
  rd_state_t  rd_state, rd_state_nxt;
  logic [7:0] wr_rem, rd_rem;
  logic       full, in_fire, out_fire, oversize;
  logic       wr_en, commit, drop, rd_done;

  // occupancy counts speculative bytes so a partial packet can fill the buffer
  assign full     = (wr_spec - rd) == ptr_t'(DEPTH);
  assign i.ready  = (wr_state == WR_DROP) || !full;
  assign in_fire  = i.valid && i.ready;
  // a packet longer than the whole buffer could never be committed
  assign oversize = (int'(i.dat) + 2) > DEPTH;

  assign o.valid  = (rd != wr_cmt);
  assign o.dat    = o.valid ? mem[rd[DEPTH_W-1:0]] : 8'h00;
  assign out_fire = o.valid && o.ready;

  // write FSM state register
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) wr_state <= WR_HDR;
    else       wr_state <= wr_state_nxt;
  end

  // write FSM next state and per-byte actions
  always_comb begin
    wr_state_nxt = wr_state;
    wr_en        = 1'b0;
    commit       = 1'b0;
    drop         = 1'b0;
    if (in_fire) begin
      case (wr_state)
        WR_HDR: begin
          wr_en        = 1'b1;
          wr_state_nxt = WR_LEN;
        end
        WR_LEN: begin
          if (oversize) begin
            drop         = 1'b1;
            wr_state_nxt = (i.dat == 8'd0) ? WR_HDR : WR_DROP;
          end else begin
            wr_en = 1'b1;
            if (i.dat == 8'd0) begin
              commit       = 1'b1;
              wr_state_nxt = WR_HDR;
            end else begin
              wr_state_nxt = WR_BODY;
            end
          end
        end
        WR_BODY: begin
          wr_en = 1'b1;
          if (wr_rem == 8'd1) begin
            commit       = 1'b1;
            wr_state_nxt = WR_HDR;
          end
        end
        WR_DROP: begin
          if (wr_rem == 8'd1) wr_state_nxt = WR_HDR;
        end
        default: wr_state_nxt = WR_HDR;
      endcase
    end
  end

  // write pointers, remaining-byte counter and drop pulse
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      wr_spec    <= '0;
      wr_cmt     <= '0;
      wr_rem     <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (drop)       wr_spec <= wr_cmt;
      else if (wr_en) wr_spec <= wr_spec + ptr_t'(1);
      if (commit)     wr_cmt  <= wr_spec + ptr_t'(1);
      if (in_fire) begin
        if (wr_state == WR_LEN)
          wr_rem <= i.dat;
        else if (wr_state == WR_BODY || wr_state == WR_DROP)
          wr_rem <= wr_rem - 8'd1;
      end
    end
  end

  // packet storage; contents need no reset since pointers gate visibility
  always_ff @(posedge uclock) begin
    if (wr_en) mem[wr_spec[DEPTH_W-1:0]] <= i.dat;
  end

  // read FSM state register
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) rd_state <= RD_HDR;
    else       rd_state <= rd_state_nxt;
  end

  // read FSM tracks packet boundaries to know when a packet has left
  always_comb begin
    rd_state_nxt = rd_state;
    rd_done      = 1'b0;
    if (out_fire) begin
      case (rd_state)
        RD_HDR: rd_state_nxt = RD_LEN;
        RD_LEN: begin
          if (o.dat == 8'd0) begin
            rd_done      = 1'b1;
            rd_state_nxt = RD_HDR;
          end else begin
            rd_state_nxt = RD_BODY;
          end
        end
        RD_BODY: begin
          if (rd_rem == 8'd1) begin
            rd_done      = 1'b1;
            rd_state_nxt = RD_HDR;
          end
        end
        default: rd_state_nxt = RD_HDR;
      endcase
    end
  end

  // read pointer, read remaining counter and committed-packet count
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      rd        <= '0;
      rd_rem    <= '0;
      pkt_avail <= '0;
    end else begin
      if (out_fire) begin
        rd <= rd + ptr_t'(1);
        if (rd_state == RD_LEN)       rd_rem <= o.dat;
        else if (rd_state == RD_BODY) rd_rem <= rd_rem - 8'd1;
      end
      case ({commit, rd_done})
        2'b10:   pkt_avail <= pkt_avail + 1'b1;
        2'b01:   pkt_avail <= pkt_avail - 1'b1;
        default: pkt_avail <= pkt_avail;
      endcase
    end
  end

`ifdef TBLINK_RPC_PKTBUF_STATS_EN
  // forwarded/dropped packet counters, free-running with wrap
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      stat_pkts  <= 16'd0;
      stat_drops <= 16'd0;
    end else begin
      if (rd_done) stat_pkts  <= stat_pkts + 16'd1;
      if (drop)    stat_drops <= stat_drops + 16'd1;
    end
  end
`else
  assign stat_pkts  = 16'd0;
  assign stat_drops = 16'd0;
`endif

endmodule

// File: tb/tb_tblink_rpc_pktbuf.sv
// Bench for tblink_rpc_pktbuf: a queue-based packet model predicts every
// output each cycle; directed scenarios add literal checks on the output log.
module tb_tblink_rpc_pktbuf;
  localparam int DEPTH = 64;
  localparam int DW    = 6;

  logic          uclock = 1'b0;
  logic          reset  = 1'b1;
  logic [DW:0]   pkt_avail;
  logic          drop_pulse;
  logic [15:0]   stat_pkts, stat_drops;

  tblink_rpc_pktbuf_if in_if ();
  tblink_rpc_pktbuf_if out_if ();

  tblink_rpc_pktbuf #(.DEPTH(DEPTH)) dut (
    .uclock     (uclock),
    .reset      (reset),
    .i          (in_if),
    .o          (out_if),
    .pkt_avail  (pkt_avail),
    .drop_pulse (drop_pulse),
    .stat_pkts  (stat_pkts),
    .stat_drops (stat_drops)
  );

  always #5 uclock = ~uclock;

  int tests = 0;
  int fails = 0;

  // model state: committed unread bytes, packet in progress, committed packet sizes
  byte unsigned q_out[$];
  byte unsigned part[$];
  int           pktq[$];
  int           drop_left = 0;
  int           in_acc = 0;
  logic         m_drop = 1'b0;
  logic [15:0]  m_pkts = 16'd0;
  logic [15:0]  m_drops = 16'd0;

  byte unsigned got[$];
  byte unsigned exp_q[$];
  int           drop_seen = 0;
  int           max_avail = 0;
  int           rd_mode = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic bit m_i_ready();
    return (drop_left > 0) || ((q_out.size() + part.size()) != DEPTH);
  endfunction

  // reference model advances on each clock edge using pre-edge state
  always @(posedge uclock or posedge reset) begin
    bit ir;
    if (reset) begin
      q_out.delete(); part.delete(); pktq.delete();
      drop_left = 0; m_drop = 1'b0; m_pkts = 16'd0; m_drops = 16'd0;
    end else begin
      ir = m_i_ready();
      m_drop = 1'b0;
      if (out_if.ready && q_out.size() > 0) begin
        void'(q_out.pop_front());
        pktq[0] = pktq[0] - 1;
        if (pktq[0] == 0) begin
          void'(pktq.pop_front());
          m_pkts = m_pkts + 16'd1;
        end
      end
      if (in_if.valid && ir) begin
        in_acc++;
        if (drop_left > 0) drop_left--;
        else begin
          part.push_back(in_if.dat);
          if (part.size() == 2 && int'(part[1]) + 2 > DEPTH) begin
            drop_left = int'(part[1]);
            part.delete();
            m_drop = 1'b1;
            m_drops = m_drops + 16'd1;
          end else if (part.size() >= 2 && part.size() == int'(part[1]) + 2) begin
            foreach (part[k]) q_out.push_back(part[k]);
            pktq.push_back(part.size());
            part.delete();
          end
        end
      end
    end
  end

  // compare DUT against the model mid-cycle and log output transfers
  always @(negedge uclock) begin
    chk("i_ready", int'(in_if.ready), int'(m_i_ready()));
    chk("o_valid", int'(out_if.valid), int'(q_out.size() > 0));
    if (q_out.size() > 0) chk("o_dat", int'(out_if.dat), int'(q_out[0]));
    if (reset) chk("o_dat_reset", int'(out_if.dat), 0);
    chk("pkt_avail", int'(pkt_avail), pktq.size());
    chk("drop_pulse", int'(drop_pulse), int'(m_drop));
`ifdef TBLINK_RPC_PKTBUF_STATS_EN
    chk("stat_pkts", int'(stat_pkts), int'(m_pkts));
    chk("stat_drops", int'(stat_drops), int'(m_drops));
`else
    chk("stat_pkts", int'(stat_pkts), 0);
    chk("stat_drops", int'(stat_drops), 0);
`endif
    if (out_if.valid && out_if.ready) got.push_back(out_if.dat);
    if (drop_pulse) drop_seen++;
    if (int'(pkt_avail) > max_avail) max_avail = int'(pkt_avail);
  end

  // downstream ready pattern: 0 always, 1 stalled, 2 random
  always @(posedge uclock) begin
    #1;
    case (rd_mode)
      0:       out_if.ready = 1'b1;
      1:       out_if.ready = 1'b0;
      default: out_if.ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send(input byte unsigned b);
    int n = 0;
    int target;
    in_if.valid = 1'b1;
    in_if.dat   = b;
    target = in_acc + 1;
    while (in_acc < target && n < 5000) begin
      @(posedge uclock); #1;
      n++;
    end
    if (in_acc < target) chk("send_timeout", in_acc, target);
    in_if.valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_out.size() > 0 || part.size() > 0) && n < 5000) begin
      @(posedge uclock); #1;
      n++;
    end
    if (q_out.size() > 0 || part.size() > 0) chk("drain_timeout", q_out.size(), 0);
    repeat (2) begin @(posedge uclock); #1; end
  endtask

  task automatic check_got(input string name);
    chk({name, "_len"}, got.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got.size(); k++)
      chk(name, int'(got[k]), int'(exp_q[k]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, pk0;
    byte unsigned b;
    int len;
    in_if.valid = 1'b0;
    in_if.dat   = 8'h00;
    out_if.ready = 1'b1;
    repeat (3) @(posedge uclock);
    #1;
    chk("rst_i_ready", int'(in_if.ready), 1);
    chk("rst_pkt_avail", int'(pkt_avail), 0);
    reset = 1'b0;
    @(posedge uclock); #1;

    // basic forwarding
    rd_mode = 0;
    got.delete();
    send(8'h00); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
    drain();
    exp_q = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    check_got("basic");
    chk("basic_pkt_avail", int'(pkt_avail), 0);

    // zero-length packet followed by a one-byte packet
    got.delete();
    send(8'h05); send(8'h00);
    send(8'h01); send(8'h01); send(8'h7E);
    drain();
    exp_q = '{8'h05, 8'h00, 8'h01, 8'h01, 8'h7E};
    check_got("zero_len");

    // oversize drop
    got.delete();
    d0 = drop_seen;
    send(8'h02); send(8'h3F);
    for (int k = 0; k < 63; k++) send(8'($urandom));
    send(8'h00); send(8'h01); send(8'h55);
    drain();
    exp_q = '{8'h00, 8'h01, 8'h55};
    check_got("drop");
    chk("drop_count", drop_seen - d0, 1);
`ifdef TBLINK_RPC_PKTBUF_STATS_EN
    chk("drop_stat", int'(stat_drops), 1);
`endif

    // full buffer backpressure
    rd_mode = 1;
    @(posedge uclock); #1;
    got.delete();
    exp_q.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'h3E);
    for (int k = 0; k < 62; k++) exp_q.push_back(8'($urandom));
    foreach (exp_q[k]) send(exp_q[k]);
    chk("full_i_ready", int'(in_if.ready), 0);
    chk("full_pkt_avail", int'(pkt_avail), 1);
    rd_mode = 0;
    drain();
    check_got("full");
    chk("full_ready_back", int'(in_if.ready), 1);

    // wrap and concurrency under random downstream ready
    rd_mode = 2;
    got.delete();
    exp_q.delete();
    max_avail = 0;
    pk0 = int'(stat_pkts);
    for (int p = 0; p < 20; p++) begin
      send(8'h00); exp_q.push_back(8'h00);
      send(8'h09); exp_q.push_back(8'h09);
      for (int k = 0; k < 9; k++) begin
        b = 8'($urandom);
        send(b); exp_q.push_back(b);
      end
    end
    drain();
    check_got("wrap");
    chk("wrap_max_avail_le6", int'(max_avail <= 6), 1);
`ifdef TBLINK_RPC_PKTBUF_STATS_EN
    chk("wrap_stat_pkts", int'(stat_pkts) - pk0, 20);
`endif

    // random packet mix, some oversized, checked by the model only
    for (int p = 0; p < 12; p++) begin
      len = $urandom_range(0, 70);
      send(8'($urandom));
      send(8'(len));
      for (int k = 0; k < len; k++) send(8'($urandom));
    end
    drain();

    // reset in the middle of a packet
    rd_mode = 0;
    got.delete();
    send(8'h00); send(8'h04); send(8'h11);
    reset = 1'b1;
    repeat (2) begin @(posedge uclock); #1; end
    chk("rst_mid_o_valid", int'(out_if.valid), 0);
    chk("rst_mid_pkt_avail", int'(pkt_avail), 0);
    reset = 1'b0;
    @(posedge uclock); #1;
    got.delete();
    send(8'h00); send(8'h01); send(8'h22);
    drain();
    exp_q = '{8'h00, 8'h01, 8'h22};
    check_got("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
